// File: rtl/cpc_rom_bank_ctrl.sv
// cpc_rom_bank_ctrl: upper-ROM bank controller for CPC expansion ROM boards.
// Watches the ROM-select I/O write (&DFxx), latches the ROM number and maps
// a DIP-selected window of NUM_ROMS 16K slots onto 28C256-class devices.
// Optional EEPROM in-system write path is compiled in with CPC_ROM_WRITE_EN.
//
// Write FSM (only with CPC_ROM_WRITE_EN)
//   state | meaning
//   IDLE  | no EEPROM write in progress
//   PULSE | rom_we_b low, device selected, for WE_CYCLES clocks
//   HOLD  | rom_we_b high, device kept selected until WR_B returns high
module cpc_rom_bank_ctrl #(
  parameter int NUM_ROMS        = 6,
  parameter int ROMS_PER_DEVICE = 2,
  parameter int WE_CYCLES       = 1,
  localparam int NUM_DEVICES    = (NUM_ROMS + ROMS_PER_DEVICE - 1) / ROMS_PER_DEVICE
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   A15,
  input  logic                   A14,
  input  logic                   A13,
  input  logic [7:0]             D,
  input  logic                   IOREQ_B,
  input  logic                   MREQ_B,
  input  logic                   RD_B,
  input  logic                   WR_B,
  input  logic                   ROMEN_B,
  input  logic [7:0]             dip,
  output logic [NUM_DEVICES-1:0] romcs_b,
  output logic                   romoe_b,
  output logic                   roma14,
  output logic                   romdis
`ifdef CPC_ROM_WRITE_EN
  ,
  output logic                   rom_we_b
`endif
);

  logic       iow_q;
  logic       iow_q2;
  logic [7:0] d_q;
  logic [7:0] rom_num;
  logic       hit;
  logic [4:0] sel_idx;
  logic [4:0] dev_idx;
  logic [7:0] base;
  logic [7:0] diff;
  logic       upper_rd;
  logic       wr_act;
  logic       sel_hold;

  assign base     = {3'b000, dip[4:0]};
  assign diff     = rom_num - base;
  assign upper_rd = ~ROMEN_B & ~RD_B & A15 & A14;

  // Sample the ROM-select I/O strobe and the data bus every clock.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      iow_q  <= 1'b0;
      iow_q2 <= 1'b0;
      d_q    <= 8'h00;
    end else begin
      iow_q  <= ~IOREQ_B & ~WR_B & ~A13;
      iow_q2 <= iow_q;
      d_q    <= D;
    end
  end

  // Latch the ROM number once per strobe, using the first sampled data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rom_num <= 8'h00;
    end else if (iow_q & ~iow_q2) begin
      rom_num <= d_q;
    end
  end

  // Window decode; the slot index is frozen while an EEPROM write is running.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit     <= 1'b0;
      sel_idx <= 5'd0;
    end else begin
      hit <= dip[7] & (rom_num >= base) & (diff < 8'(NUM_ROMS));
      if (!sel_hold) begin
        sel_idx <= diff[4:0];
      end
    end
  end

  assign dev_idx = (ROMS_PER_DEVICE == 2) ? {1'b0, sel_idx[4:1]} : sel_idx;
  assign roma14  = (ROMS_PER_DEVICE == 2) ? sel_idx[0] : 1'b0;
  assign romoe_b = ~(upper_rd & hit & ~wr_act);
  assign romdis  = upper_rd & hit;

  // Per-device chip select: one device at most, only on a hit.
  always_comb begin
    romcs_b = '1;
    for (int k = 0; k < NUM_DEVICES; k++) begin
      if (hit && (upper_rd || wr_act) && (dev_idx == 5'(k))) begin
        romcs_b[k] = 1'b0;
      end
    end
  end

`ifdef CPC_ROM_WRITE_EN
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} wr_state_t;

  wr_state_t  state;
  wr_state_t  state_nxt;
  logic [3:0] we_cnt;
  logic [3:0] we_cnt_nxt;
  logic       upper_wr;
  logic       unused_cfg;

  assign upper_wr   = ~MREQ_B & ~WR_B & A15 & A14 & hit & dip[6];
  assign sel_hold   = wr_act;
  assign unused_cfg = dip[5];

  // Write FSM state and pulse-length down-counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      we_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      we_cnt <= we_cnt_nxt;
    end
  end

  // Write FSM next state and outputs; pulse ends at terminal count zero.
  always_comb begin
    state_nxt  = state;
    we_cnt_nxt = we_cnt;
    rom_we_b   = 1'b1;
    wr_act     = 1'b0;
    case (state)
      IDLE: begin
        if (upper_wr) begin
          state_nxt  = PULSE;
          we_cnt_nxt = 4'(WE_CYCLES - 1);
        end
      end
      PULSE: begin
        rom_we_b = 1'b0;
        wr_act   = 1'b1;
        if (we_cnt == 4'd0) begin
          state_nxt = HOLD;
        end else begin
          we_cnt_nxt = we_cnt - 4'd1;
        end
      end
      HOLD: begin
        wr_act = 1'b1;
        if (WR_B) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  logic unused_cfg;

  assign wr_act     = 1'b0;
  assign sel_hold   = 1'b0;
  assign unused_cfg = &{dip[6:5], MREQ_B};
`endif

endmodule

// File: tb/tb_cpc_rom_bank_ctrl.sv
// Self-checking bench for cpc_rom_bank_ctrl (6 slots, 2 per device, 3 devices).
module tb_cpc_rom_bank_ctrl;

  localparam int NROMS = 6;
  localparam int RPD   = 2;
  localparam int WE    = 3;
  localparam int NDEV  = 3;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            A15, A14, A13;
  logic [7:0]      D;
  logic            IOREQ_B, MREQ_B, RD_B, WR_B, ROMEN_B;
  logic [7:0]      dip;
  logic [NDEV-1:0] romcs_b;
  logic            romoe_b, roma14, romdis;
`ifdef CPC_ROM_WRITE_EN
  logic            rom_we_b;
`endif

  typedef struct {
    string      tag;
    logic [4:0] exp;      // {romcs_b[2:0], romoe_b, romdis}
    logic       care_a14;
    logic       a14;
  } sb_t;

  sb_t        sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_rom;

  always #5 CLK = ~CLK;

  cpc_rom_bank_ctrl #(
    .NUM_ROMS       (NROMS),
    .ROMS_PER_DEVICE(RPD),
    .WE_CYCLES      (WE)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .A15     (A15),
    .A14     (A14),
    .A13     (A13),
    .D       (D),
    .IOREQ_B (IOREQ_B),
    .MREQ_B  (MREQ_B),
    .RD_B    (RD_B),
    .WR_B    (WR_B),
    .ROMEN_B (ROMEN_B),
    .dip     (dip),
    .romcs_b (romcs_b),
    .romoe_b (romoe_b),
    .roma14  (roma14),
    .romdis  (romdis)
`ifdef CPC_ROM_WRITE_EN
    ,
    .rom_we_b(rom_we_b)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  task automatic bus_idle();
    A15 = 1'b0; A14 = 1'b0; A13 = 1'b0; D = 8'h00;
    IOREQ_B = 1'b1; MREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; ROMEN_B = 1'b1;
  endtask

  // Expected outputs for a registered rom number / dip seen by the decode.
  task automatic sb_push(input string tag, input logic urd, input logic [7:0] rom,
                         input logic [7:0] dp);
    sb_t        e;
    logic [7:0] b, df;
    logic       h;
    logic [2:0] cs;
    int         dev;
    b   = {3'b000, dp[4:0]};
    df  = rom - b;
    h   = dp[7] && (rom >= b) && (df < 8'(NROMS));
    cs  = 3'b111;
    dev = int'(df) / RPD;
    if (h && urd) cs[dev] = 1'b0;
    e.tag      = tag;
    e.exp      = {cs, ~(h & urd), h & urd};
    e.care_a14 = h;
    e.a14      = df[0];
    sb.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    chk("sb_depth", 8'(sb.size()), 8'd1);
    e = sb.pop_front();
    chk(e.tag, 8'({romcs_b, romoe_b, romdis}), 8'(e.exp));
    if (e.care_a14) chk({e.tag, "_a14"}, 8'(roma14), 8'(e.a14));
  endtask

  task automatic io_wr(input logic [7:0] d0, input logic [7:0] d1, input logic a13, input int n);
    A15 = 1'b1; A14 = 1'b1; A13 = a13; IOREQ_B = 1'b0; WR_B = 1'b0; D = d0;
    for (int i = 0; i < n; i++) begin
      tick();
      D = d1;
    end
    IOREQ_B = 1'b1; WR_B = 1'b1; A13 = 1'b0; D = 8'h00;
    if (!a13) m_rom = d0;
  endtask

  task automatic rd_check(input string tag, input logic lower);
    ROMEN_B = 1'b0; RD_B = 1'b0; A15 = !lower; A14 = !lower;
    #1;
    sb_push(tag, !lower, m_rom, dip);
    sb_check();
    ROMEN_B = 1'b1; RD_B = 1'b1;
    #1;
  endtask

  task automatic upper_rd_on();
    ROMEN_B = 1'b0; RD_B = 1'b0; A15 = 1'b1; A14 = 1'b1;
  endtask

`ifdef CPC_ROM_WRITE_EN
  task automatic eeprom_write(input string tag, input int exp_len);
    int cnt;
    cnt = 0;
    MREQ_B = 1'b0; WR_B = 1'b0; A15 = 1'b1; A14 = 1'b1;
    for (int i = 0; i < WE + 3; i++) begin
      tick();
      if (!rom_we_b) cnt++;
    end
    chk({tag, "_we_len"}, 8'(cnt), 8'(exp_len));
    chk({tag, "_oe"}, 8'(romoe_b), 8'd1);
    if (exp_len > 0) chk({tag, "_cs_hold"}, 8'(romcs_b), 8'b101);
    else             chk({tag, "_cs_idle"}, 8'(romcs_b), 8'b111);
    WR_B = 1'b1; MREQ_B = 1'b1;
    tick();
    chk({tag, "_cs_release"}, 8'(romcs_b), 8'b111);
    chk({tag, "_we_release"}, 8'(rom_we_b), 8'd1);
    bus_idle();
  endtask
`endif

  initial begin
    bus_idle();
    dip   = 8'h81;
    m_rom = 8'h00;
    RESET = 1'b1;
    settle();
    sb_push("reset_idle", 1'b0, m_rom, dip);
    sb_check();
    rd_check("reset_rd", 1'b0);
    RESET = 1'b0;
    tick();

    // Basic selection and window edges (window 1..6)
    io_wr(8'd3, 8'd3, 1'b0, 1); settle(); rd_check("rom3", 1'b0);
    io_wr(8'd7, 8'd7, 1'b0, 1); settle(); rd_check("rom7_miss", 1'b0);
    io_wr(8'd0, 8'd0, 1'b0, 1); settle(); rd_check("rom0_miss", 1'b0);
    io_wr(8'd6, 8'd6, 1'b0, 1); settle(); rd_check("rom6", 1'b0);
    io_wr(8'd1, 8'd1, 1'b0, 1); settle(); rd_check("rom1", 1'b0);

    // Board disable, then re-enable takes effect one edge later
    io_wr(8'd3, 8'd3, 1'b0, 1); settle();
    dip = 8'h01; tick(); rd_check("disabled", 1'b0);
    upper_rd_on();
    dip = 8'h81;
    #1;
    sb_push("enable_same_cycle", 1'b1, m_rom, 8'h01); sb_check();
    tick();
    sb_push("enable_next_edge", 1'b1, m_rom, 8'h81); sb_check();
    bus_idle();

    // A13=1 I/O write is not the ROM select port
    io_wr(8'd5, 8'd5, 1'b1, 1); settle(); rd_check("a13_ignored", 1'b0);

    // Held strobe: latch once, first data, outputs change on edge 2
    io_wr(8'd6, 8'd6, 1'b0, 1); settle();
    upper_rd_on();
    A13 = 1'b0; IOREQ_B = 1'b0; WR_B = 1'b0; D = 8'd3;
    #1;
    sb_push("lat_pre", 1'b1, 8'd6, dip); sb_check();
    tick(); D = 8'd5;
    sb_push("lat_edge0", 1'b1, 8'd6, dip); sb_check();
    tick();
    sb_push("lat_edge1", 1'b1, 8'd6, dip); sb_check();
    tick();
    sb_push("lat_edge2", 1'b1, 8'd3, dip); sb_check();
    IOREQ_B = 1'b1; WR_B = 1'b1; D = 8'h00;
    m_rom = 8'd3;
    tick();
    sb_push("lat_first_data", 1'b1, m_rom, dip); sb_check();
    bus_idle();
    tick();

    // Lower-ROM access never hits
    rd_check("lower_rom", 1'b1);

    // Reset mid-selection
    upper_rd_on();
    RESET = 1'b1;
    #1;
    sb_push("rst_before_edge", 1'b1, m_rom, dip); sb_check();
    tick();
    m_rom = 8'h00;
    sb_push("rst_after_edge", 1'b1, m_rom, dip); sb_check();
    RESET = 1'b0;
    bus_idle();
    tick();

`ifdef CPC_ROM_WRITE_EN
    dip = 8'hC1;
    io_wr(8'd3, 8'd3, 1'b0, 1); settle();
    eeprom_write("wr_unlocked", WE);
    dip = 8'h81; tick();
    eeprom_write("wr_locked", 0);
    dip = 8'hC1; tick();
    MREQ_B = 1'b0; WR_B = 1'b0; A15 = 1'b1; A14 = 1'b1;
    tick();
    chk("wr_pulse_on", 8'(rom_we_b), 8'd0);
    RESET = 1'b1;
    tick();
    chk("wr_reset_we", 8'(rom_we_b), 8'd1);
    chk("wr_reset_cs", 8'(romcs_b), 8'b111);
    RESET = 1'b0;
    bus_idle();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
